pc_next_unit: RTL

//   Program-counter stage of the multi-cycle MIPS datapath. Holds the PC register.

---
 rtl/pc_next_unit_if.sv | 32 +++
 rtl/pc_next_unit.sv | 70 +++++++
 2 files changed

// File: rtl/pc_next_unit_if.sv
// Bus between the control/immediate stages and the program-counter stage.
// The control side is the master; the PC unit is the slave.
interface pc_next_unit_if #(
    parameter int WIDTH = 32
);
    logic             pc_write;
    logic             pc_write_cond;
    logic             branch_ne;
    logic             zero;
    logic [1:0]       pc_src;
    logic             bt_write;
    logic [WIDTH-1:0] disp_in;
    logic [25:0]      jump_idx;
    logic [WIDTH-1:0] reg_target;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] branch_target;
    logic             pc_updated;
    logic             addr_err;

    modport master (
        output pc_write, pc_write_cond, branch_ne, zero, pc_src,
               bt_write, disp_in, jump_idx, reg_target,
        input  pc, pc_plus4, branch_target, pc_updated, addr_err
    );

    modport slave (
        input  pc_write, pc_write_cond, branch_ne, zero, pc_src,
               bt_write, disp_in, jump_idx, reg_target,
        output pc, pc_plus4, branch_target, pc_updated, addr_err
    );
endinterface

// File: rtl/pc_next_unit.sv
// Program-counter stage of the multi-cycle MIPS datapath: holds the PC, latches
// the branch target and commits the next PC under control-unit enables.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          WIDTH    = 32
) (
    input  logic           i_clk,
    input  logic           i_rst,
    pc_next_unit_if.slave  bus
);
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_branch_target;
    logic             r_pc_updated;
    logic             r_addr_err;

    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_jump_target;
    logic [WIDTH-1:0] w_bt_sum;
    logic [WIDTH-1:0] w_pc_next;
    logic             w_commit;
    logic             w_jr_misaligned;

    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_jump_target = {r_pc[31:28], bus.jump_idx, 2'b00};
    assign w_bt_sum      = r_pc + bus.disp_in;

    assign w_commit = bus.pc_write |
                      (bus.pc_write_cond & (bus.zero ^ bus.branch_ne));

    // A jr to a non-word-aligned address is refused rather than committed.
    assign w_jr_misaligned = w_commit && (bus.pc_src == 2'b11) &&
                             (bus.reg_target[1:0] != 2'b00);

    always_comb begin
        w_pc_next = w_pc_plus4;
        case (bus.pc_src)
            2'b00:   w_pc_next = w_pc_plus4;
            2'b01:   w_pc_next = r_branch_target;
            2'b10:   w_pc_next = w_jump_target;
            default: w_pc_next = bus.reg_target;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc            <= RESET_PC;
            r_branch_target <= '0;
            r_pc_updated    <= 1'b0;
            r_addr_err      <= 1'b0;
        end else begin
            // Branch target sums against the pre-commit PC on the same edge.
            if (bus.bt_write) begin
                r_branch_target <= w_bt_sum;
            end
            if (w_commit && !w_jr_misaligned) begin
                r_pc <= w_pc_next;
            end
            if (w_jr_misaligned) begin
                r_addr_err <= 1'b1;
            end
            r_pc_updated <= w_commit && !w_jr_misaligned;
        end
    end

    assign bus.pc            = r_pc;
    assign bus.pc_plus4      = w_pc_plus4;
    assign bus.branch_target = r_branch_target;
    assign bus.pc_updated    = r_pc_updated;
    assign bus.addr_err      = r_addr_err;
endmodule
